// File: rtl/timer_host_pkg.sv
// Shared types for the machine-timer bus initiator: command ops, FSM states,
// timer register addresses and the per-op beat tables.
package timer_host_pkg;

    typedef enum logic [1:0] {
        RD_TIME = 2'd0,
        RD_CMP  = 2'd1,
        WR_CMP  = 2'd2,
        WR_TIME = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [4:0] MTIME_LO    = 5'd0;
    localparam logic [4:0] MTIME_HI    = 5'd4;
    localparam logic [4:0] MTIMECMP_LO = 5'd8;
    localparam logic [4:0] MTIMECMP_HI = 5'd16;

    // One 32-bit bus access of a command sequence.
    typedef struct packed {
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    // Number of bus beats a command needs.
    function automatic logic [1:0] op_beats(op_e op);
        return (op == RD_CMP) ? 2'd2 : 2'd3;
    endfunction

    // Bus access for a given op/beat index. Write orderings are chosen so
    // that mtimecmp never dips below its target (hi parked at all-ones first)
    // and mtime never carries into hi mid-sequence (lo cleared first).
    function automatic beat_t beat_of(op_e op, logic [1:0] beat, logic [63:0] d);
        beat_t b;
        b.addr  = MTIME_LO;
        b.we    = 1'b0;
        b.wdata = 32'h0;
        case ({op, beat})
            {RD_TIME, 2'd0}: b.addr = MTIME_HI;
            {RD_TIME, 2'd1}: b.addr = MTIME_LO;
            {RD_TIME, 2'd2}: b.addr = MTIME_HI;
            {RD_CMP,  2'd0}: b.addr = MTIMECMP_LO;
            {RD_CMP,  2'd1}: b.addr = MTIMECMP_HI;
            {WR_CMP,  2'd0}: begin b.addr = MTIMECMP_HI; b.we = 1'b1; b.wdata = 32'hFFFF_FFFF; end
            {WR_CMP,  2'd1}: begin b.addr = MTIMECMP_LO; b.we = 1'b1; b.wdata = d[31:0];      end
            {WR_CMP,  2'd2}: begin b.addr = MTIMECMP_HI; b.we = 1'b1; b.wdata = d[63:32];     end
            {WR_TIME, 2'd0}: begin b.addr = MTIME_LO;    b.we = 1'b1; b.wdata = 32'h0;        end
            {WR_TIME, 2'd1}: begin b.addr = MTIME_HI;    b.we = 1'b1; b.wdata = d[63:32];     end
            {WR_TIME, 2'd2}: begin b.addr = MTIME_LO;    b.we = 1'b1; b.wdata = d[31:0];      end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_host_ctrl.sv
// Bus initiator for the 64-bit machine timer: splits one 64-bit command into
// a sequence of single-outstanding 32-bit accesses, with tear-free mtime
// reads (hi/lo/hi with bounded retry), response timeout and error abort.
module timer_host_ctrl
    import timer_host_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 8,
    parameter int MaxRetries    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [63:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        timer_req_o,
    output logic [4:0]  timer_addr_o,
    output logic        timer_we_o,
    output logic [3:0]  timer_be_o,
    output logic [31:0] timer_wdata_o,
    input  logic        timer_rvalid_i,
    input  logic [31:0] timer_rdata_i,
    input  logic        timer_err_i
);

    // Parameter sanity, caught at elaboration.
    if (DataWidth != 32) begin : g_bad_width
        $error("timer_host_ctrl: DataWidth must be 32");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("timer_host_ctrl: TimeoutCycles must be >= 2");
    end
    if (MaxRetries < 1) begin : g_bad_retries
        $error("timer_host_ctrl: MaxRetries must be >= 1");
    end

    localparam int TW = $clog2(TimeoutCycles);
    localparam int RW = (MaxRetries > 1) ? $clog2(MaxRetries) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TimeoutCycles - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MaxRetries - 1);

    state_e        state;
    op_e           op;
    logic [63:0]   wdata;
    logic [1:0]    beat;
    logic [RW-1:0] retry;
    logic [TW-1:0] tmo;
    logic [31:0]   h1;
    logic [31:0]   lo;

    beat_t first_b;
    beat_t next_b;
    beat_t restart_b;
    logic  last;
    logic  hi_match;
    logic  retry_out;

    // Bus access lookups for the accepting command, the following beat and
    // a restart of the current op; plus the end-of-sequence decisions.
    always_comb begin
        first_b   = beat_of(op_e'(cmd_op_i), 2'd0, cmd_wdata_i);
        next_b    = beat_of(op, beat + 2'd1, wdata);
        restart_b = beat_of(op, 2'd0, wdata);
        last      = (beat == (op_beats(op) - 2'd1));
        hi_match  = (timer_rdata_i == h1);
        retry_out = (retry == RETRY_LAST);
    end

    assign timer_be_o = 4'hF;

    // Command FSM: IDLE -> ISSUE -> WAIT (-> ISSUE per beat) -> RESP -> IDLE.
    // All bus and response outputs are registered here. The request for a
    // beat is launched on the edge that enters ISSUE, so req is high for
    // exactly the ISSUE cycle. The response is posted one edge after RESP is
    // entered, with data/err already settled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            op            <= RD_TIME;
            wdata         <= 64'h0;
            beat          <= 2'd0;
            retry         <= '0;
            tmo           <= '0;
            h1            <= 32'h0;
            lo            <= 32'h0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= 64'h0;
            rsp_err_o     <= 1'b0;
            timer_req_o   <= 1'b0;
            timer_addr_o  <= 5'd0;
            timer_we_o    <= 1'b0;
            timer_wdata_o <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op            <= op_e'(cmd_op_i);
                        wdata         <= cmd_wdata_i;
                        beat          <= 2'd0;
                        retry         <= '0;
                        rsp_data_o    <= 64'h0;
                        rsp_err_o     <= 1'b0;
                        cmd_ready_o   <= 1'b0;
                        timer_req_o   <= 1'b1;
                        timer_addr_o  <= first_b.addr;
                        timer_we_o    <= first_b.we;
                        timer_wdata_o <= first_b.wdata;
                        state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    timer_req_o <= 1'b0;
                    timer_we_o  <= 1'b0;
                    tmo         <= '0;
                    state       <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (timer_rvalid_i) begin
                        if (timer_err_i) begin
                            // Abort: remaining beats are dropped.
                            rsp_data_o <= 64'h0;
                            rsp_err_o  <= 1'b1;
                            state      <= ST_RESP;
                        end else if (last) begin
                            case (op)
                                RD_TIME: begin
                                    if (hi_match) begin
                                        rsp_data_o <= {h1, lo};
                                        state      <= ST_RESP;
                                    end else if (retry_out) begin
                                        rsp_data_o <= 64'h0;
                                        rsp_err_o  <= 1'b1;
                                        state      <= ST_RESP;
                                    end else begin
                                        // lo wrapped between the hi reads: start over.
                                        retry         <= retry + 1'b1;
                                        beat          <= 2'd0;
                                        timer_req_o   <= 1'b1;
                                        timer_addr_o  <= restart_b.addr;
                                        timer_we_o    <= restart_b.we;
                                        timer_wdata_o <= restart_b.wdata;
                                        state         <= ST_ISSUE;
                                    end
                                end
                                RD_CMP: begin
                                    rsp_data_o <= {timer_rdata_i, lo};
                                    state      <= ST_RESP;
                                end
                                default: begin
                                    rsp_data_o <= 64'h0;
                                    state      <= ST_RESP;
                                end
                            endcase
                        end else begin
                            // Capture intermediate read words; harmless for writes.
                            if (op == RD_TIME && beat == 2'd0) begin
                                h1 <= timer_rdata_i;
                            end else begin
                                lo <= timer_rdata_i;
                            end
                            beat          <= beat + 2'd1;
                            timer_req_o   <= 1'b1;
                            timer_addr_o  <= next_b.addr;
                            timer_we_o    <= next_b.we;
                            timer_wdata_o <= next_b.wdata;
                            state         <= ST_ISSUE;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Gave up on this beat; any later rvalid lands outside WAIT.
                        rsp_data_o <= 64'h0;
                        rsp_err_o  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (!rsp_valid_o) begin
                        rsp_valid_o <= 1'b1;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Directed bench for timer_host_ctrl: a behavioural mtime/mtimecmp responder
// with fault knobs (hi word churn, muted rvalid, bus error, late rvalid),
// response and bus-beat scoreboards, and immediate-assertion checks.
module tb_timer_host_ctrl;

    localparam int TC = 8;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        timer_req;
    logic [4:0]  timer_addr;
    logic        timer_we;
    logic [3:0]  timer_be;
    logic [31:0] timer_wdata;
    logic        timer_rvalid;
    logic [31:0] timer_rdata;
    logic        timer_err;

    always #5 clk = ~clk;

    timer_host_ctrl #(.DataWidth(32), .TimeoutCycles(TC), .MaxRetries(MR)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .timer_req_o(timer_req), .timer_addr_o(timer_addr),
        .timer_we_o(timer_we), .timer_be_o(timer_be),
        .timer_wdata_o(timer_wdata),
        .timer_rvalid_i(timer_rvalid), .timer_rdata_i(timer_rdata),
        .timer_err_i(timer_err)
    );

    // ---------------- timer responder model ----------------
    logic        tm_rst;
    logic [63:0] tm_mtime;
    logic [63:0] tm_cmp;
    logic        tm_rvalid;
    logic [31:0] tm_rdata;
    logic        tm_err;
    logic [31:0] hi_ctr;
    logic        stub_hi_chg;
    logic        stub_mute;
    logic        stub_err;
    logic        late_rv;
    logic        mtip;

    assign timer_rvalid = tm_rvalid | late_rv;
    assign timer_rdata  = late_rv ? 32'hDEAD_BEEF : tm_rdata;
    assign timer_err    = tm_err;
    assign mtip         = (tm_mtime >= tm_cmp);

    // mtime ticks every cycle; one response the cycle after each request.
    always @(posedge clk or posedge tm_rst) begin
        if (tm_rst) begin
            tm_mtime  <= 64'h0;
            tm_cmp    <= 64'h0;
            tm_rvalid <= 1'b0;
            tm_rdata  <= 32'h0;
            tm_err    <= 1'b0;
            hi_ctr    <= 32'h100;
        end else begin
            tm_rvalid <= 1'b0;
            tm_err    <= 1'b0;
            tm_mtime  <= tm_mtime + 64'd1;
            if (timer_req && !stub_mute) begin
                tm_rvalid <= 1'b1;
                tm_err    <= stub_err;
                if (timer_we) begin
                    case (timer_addr)
                        5'd0:  tm_mtime <= {tm_mtime[63:32], timer_wdata};
                        5'd4:  tm_mtime <= {timer_wdata, tm_mtime[31:0]};
                        5'd8:  tm_cmp   <= {tm_cmp[63:32], timer_wdata};
                        5'd16: tm_cmp   <= {timer_wdata, tm_cmp[31:0]};
                        default: ;
                    endcase
                end else begin
                    case (timer_addr)
                        5'd0:  tm_rdata <= tm_mtime[31:0];
                        5'd4:  begin
                            if (stub_hi_chg) begin
                                tm_rdata <= hi_ctr;
                                hi_ctr   <= hi_ctr + 32'd1;
                            end else begin
                                tm_rdata <= tm_mtime[63:32];
                            end
                        end
                        5'd8:  tm_rdata <= tm_cmp[31:0];
                        5'd16: tm_rdata <= tm_cmp[63:32];
                        default: tm_rdata <= 32'h0;
                    endcase
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic        err;
    } exp_t;
    typedef struct {
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    int   rd_cnt;
    int   rd4_cnt;
    logic irq_watch;
    logic irq_armed;
    logic irq_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [63:0] m, input logic e);
        exp_t x;
        x.data = d; x.mask = m; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic push_bus(input logic [4:0] a, input logic w, input logic [31:0] d);
        bus_t b;
        b.addr = a; b.we = w; b.wdata = d;
        bus_q.push_back(b);
    endtask

    // Bus monitor: counts reads, checks queued beats, watches mtip after the
    // first mtimecmp-hi write of a watched command has landed.
    always @(negedge clk) begin
        if (irq_armed && mtip) irq_bad = 1'b1;
        if (!irq_watch) irq_armed = 1'b0;
        else if (timer_req && timer_we && timer_addr == 5'd16) irq_armed = 1'b1;
        if (!rst && timer_req) begin
            if (!timer_we) begin
                rd_cnt++;
                if (timer_addr == 5'd4) rd4_cnt++;
            end
            if (bus_q.size() > 0) begin
                bus_t b;
                b = bus_q.pop_front();
                chk("bus_addr", 64'(timer_addr), 64'(b.addr));
                chk("bus_we", 64'(timer_we), 64'(b.we));
                chk("bus_wdata", 64'(timer_wdata), 64'(b.wdata));
                chk("bus_be", 64'(timer_be), 64'hF);
            end
        end
    end

    // Issue one command (called at a negedge), measure accept-to-rsp_valid
    // latency, compare against the scoreboard, check hold stability, then
    // handshake. With late=1 stray rvalid pulses are injected in RESP and IDLE.
    task automatic run_cmd(input logic [1:0] op, input logic [63:0] wd,
                           input bit late, output int lat);
        exp_t        x;
        logic [63:0] d;
        logic        e;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 64'h0;
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid === 1'b1) break;
        end
        if (rsp_valid !== 1'b1) begin
            chk("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
            return;
        end
        d = rsp_data;
        e = rsp_err;
        if (exp_q.size() == 0) begin
            chk("exp_q_nonempty", 64'd0, 64'd1);
        end else begin
            x = exp_q.pop_front();
            chk("rsp_data", d & x.mask, x.data & x.mask);
            chk("rsp_err", 64'(e), 64'(x.err));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            late_rv = late && (i == 0);
        end
        @(negedge clk);
        late_rv = 1'b0;
        chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_hold_data", rsp_data, d);
        chk("rsp_hold_err", 64'(rsp_err), 64'(e));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
        if (late) begin
            @(negedge clk); late_rv = 1'b1;
            @(negedge clk); late_rv = 1'b0;
            chk("idle_ignores_rvalid", 64'(cmd_ready), 64'd1);
            chk("idle_no_rsp", 64'(rsp_valid), 64'd0);
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  lat;
        bit  found;
        int  n;
        rst = 1'b1; tm_rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 64'h0; rsp_ready = 1'b0;
        stub_hi_chg = 1'b0; stub_mute = 1'b0; stub_err = 1'b0; late_rv = 1'b0;
        rd_cnt = 0; rd4_cnt = 0; irq_watch = 1'b0; irq_armed = 1'b0; irq_bad = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_req", 64'(timer_req), 64'd0);
        chk("rst_we", 64'(timer_we), 64'd0);
        chk("rst_addr", 64'(timer_addr), 64'd0);
        chk("rst_wdata", 64'(timer_wdata), 64'd0);
        chk("rst_be", 64'(timer_be), 64'hF);
        rst = 1'b0; tm_rst = 1'b0;
        @(negedge clk);

        // RD_CMP after timer reset: {0,0}, 2 beats -> latency 5
        push_exp(64'h0, '1, 1'b0);
        run_cmd(2'd1, 64'h0, 1'b0, lat);
        chk("rdcmp_lat", 64'(lat), 64'd5);

        // WR_CMP with exact bus order; mtip must stay low once hi is parked
        @(negedge clk);
        push_bus(5'd16, 1'b1, 32'hFFFF_FFFF);
        push_bus(5'd8,  1'b1, 32'h0000_0010);
        push_bus(5'd16, 1'b1, 32'h0000_0001);
        push_exp(64'h0, '1, 1'b0);
        irq_bad = 1'b0; irq_watch = 1'b1;
        run_cmd(2'd2, 64'h0000_0001_0000_0010, 1'b0, lat);
        irq_watch = 1'b0;
        chk("wrcmp_lat", 64'(lat), 64'd7);
        chk("wrcmp_no_irq_glitch", 64'(irq_bad), 64'd0);
        chk("wrcmp_irq_low", 64'(mtip), 64'd0);
        chk("wrcmp_bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("wrcmp_model_cmp", tm_cmp, 64'h0000_0001_0000_0010);

        // Read back mtimecmp
        @(negedge clk);
        push_exp(64'h0000_0001_0000_0010, '1, 1'b0);
        run_cmd(2'd1, 64'h0, 1'b0, lat);

        // WR_TIME ordering
        @(negedge clk);
        push_bus(5'd0, 1'b1, 32'h0);
        push_bus(5'd4, 1'b1, 32'h0);
        push_bus(5'd0, 1'b1, 32'hFFFF_FFF0);
        push_exp(64'h0, '1, 1'b0);
        run_cmd(2'd3, 64'h0000_0000_FFFF_FFF0, 1'b0, lat);
        chk("wrtime_lat", 64'(lat), 64'd7);
        chk("wrtime_bus_q_drained", 64'(bus_q.size()), 64'd0);

        // RD_TIME launched so the lo word wraps between the two hi reads:
        // first h1 read sees lo=..FFFD, h2 sees hi=1 -> one retry.
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tm_mtime[31:0] >= 32'hFFFF_FFFC) begin found = 1'b1; break; end
        end
        chk("wrap_window_reached", 64'(found), 64'd1);
        chk("wrap_hi_still_zero", 64'(tm_mtime[63:32]), 64'd0);
        rd_cnt = 0; rd4_cnt = 0;
        push_exp(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
        run_cmd(2'd0, 64'h0, 1'b0, lat);
        chk("rdtime_wrap_hi_reads", 64'(rd4_cnt), 64'd4);
        chk("rdtime_wrap_reads", 64'(rd_cnt), 64'd6);

        // Hi word changes on every read: MaxRetries attempts of 3 reads each
        @(negedge clk);
        stub_hi_chg = 1'b1; rd_cnt = 0; rd4_cnt = 0;
        push_exp(64'h0, '1, 1'b1);
        run_cmd(2'd0, 64'h0, 1'b0, lat);
        stub_hi_chg = 1'b0;
        chk("retry_total_reads", 64'(rd_cnt), 64'(3 * MR));
        chk("retry_hi_reads", 64'(rd4_cnt), 64'(2 * MR));

        // Muted responder: timeout error, late rvalid ignored
        @(negedge clk);
        stub_mute = 1'b1;
        push_exp(64'h0, '1, 1'b1);
        run_cmd(2'd1, 64'h0, 1'b1, lat);
        stub_mute = 1'b0;
        chk("tmo_lat_window", 64'((lat >= TC) && (lat <= TC + 2)), 64'd1);

        // Next command after timeout succeeds normally
        @(negedge clk);
        push_exp(64'h0000_0001_0000_0010, '1, 1'b0);
        run_cmd(2'd1, 64'h0, 1'b0, lat);
        chk("post_tmo_lat", 64'(lat), 64'd5);

        // Bus error on the first beat aborts the rest
        @(negedge clk);
        stub_err = 1'b1; rd_cnt = 0;
        push_exp(64'h0, '1, 1'b1);
        run_cmd(2'd1, 64'h0, 1'b0, lat);
        stub_err = 1'b0;
        chk("err_abort_reads", 64'(rd_cnt), 64'd1);

        // Reset while the third WR_CMP beat is on the bus
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_wdata = 64'h0000_0002_0000_0020;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 64'h0;
        found = 1'b0; n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timer_req === 1'b1) begin
                n++;
                if (n == 3) begin found = 1'b1; break; end
            end
        end
        chk("mid_rst_third_beat_seen", 64'(found), 64'd1);
        chk("mid_rst_third_beat_addr", 64'(timer_addr), 64'd16);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 64'(timer_req), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_we", 64'(timer_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Partial write stays: hi parked at all-ones, lo updated
        push_exp(64'hFFFF_FFFF_0000_0020, '1, 1'b0);
        run_cmd(2'd1, 64'h0, 1'b0, lat);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
